// File: rtl/bp_me_stream_arb_out_if.sv
// Stream bundle between N BedRock producers and one arbitrated output.
// master = arbiter side, slave = producers/consumer side.
interface bp_me_stream_arb_out_if #(
  parameter int num_req_p           = 4,
  parameter int header_width_p      = 128,
  parameter int stream_data_width_p = 64
);
  logic [num_req_p*header_width_p-1:0]      req_header_i;
  logic [num_req_p*stream_data_width_p-1:0] req_data_i;
  logic [num_req_p-1:0]                     req_v_i;
  logic [num_req_p-1:0]                     req_last_i;
  logic [num_req_p-1:0]                     req_ready_and_o;

  logic [header_width_p-1:0]      mem_header_o;
  logic [stream_data_width_p-1:0] mem_data_o;
  logic                           mem_v_o;
  logic                           mem_last_o;
  logic                           mem_ready_and_i;

  modport master (
    input  req_header_i,
    input  req_data_i,
    input  req_v_i,
    input  req_last_i,
    output req_ready_and_o,
    output mem_header_o,
    output mem_data_o,
    output mem_v_o,
    output mem_last_o,
    input  mem_ready_and_i
  );

  modport slave (
    output req_header_i,
    output req_data_i,
    output req_v_i,
    output req_last_i,
    input  req_ready_and_o,
    input  mem_header_o,
    input  mem_data_o,
    input  mem_v_o,
    input  mem_last_o,
    output mem_ready_and_i
  );
endinterface

// File: rtl/bp_me_stream_arb_out.sv
// N:1 BedRock stream arbiter; locks on a requester for a whole message.
// Define BP_ME_STREAM_ARB_OUT_RR_EN for round-robin, else fixed priority.
module bp_me_stream_arb_out #(
  parameter int num_req_p           = 4,
  parameter int header_width_p      = 128,
  parameter int stream_data_width_p = 64,
  localparam int lg_num_req_lp      = $clog2(num_req_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  bp_me_stream_arb_out_if.master   io,
  output logic [lg_num_req_lp-1:0] grant_id_o,
  output logic                     locked_o
);

  typedef logic [lg_num_req_lp-1:0] id_t;
  typedef logic [lg_num_req_lp:0]   cnt_t;

  typedef enum logic {
    e_idle,
    e_locked
  } state_e;

  state_e state_r, state_n;
  id_t    lock_id_r, lock_id_n;
  id_t    pick;
  id_t    winner;
  logic   hs;

`ifdef BP_ME_STREAM_ARB_OUT_RR_EN
  id_t rr_ptr_r, rr_ptr_n;

  // lowest offset from rr_ptr_r wins, so scan offsets downward
  always_comb begin
    cnt_t idx;
    pick = '0;
    idx  = '0;
    for (int k = num_req_p-1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr_r} + cnt_t'(k);
      if (idx >= cnt_t'(num_req_p))
        idx = idx - cnt_t'(num_req_p);
      if (io.req_v_i[idx[lg_num_req_lp-1:0]])
        pick = idx[lg_num_req_lp-1:0];
    end
  end

  always_comb begin
    rr_ptr_n = rr_ptr_r;
    if (hs && io.mem_last_o) begin
      if (winner == id_t'(num_req_p-1))
        rr_ptr_n = '0;
      else
        rr_ptr_n = winner + id_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      rr_ptr_r <= '0;
    else
      rr_ptr_r <= rr_ptr_n;
  end
`else
  always_comb begin
    pick = '0;
    for (int k = num_req_p-1; k >= 0; k--) begin
      if (io.req_v_i[k])
        pick = id_t'(k);
    end
  end
`endif

  assign winner = (state_r == e_locked) ? lock_id_r : pick;

  // outputs are forced low while reset is held
  always_comb begin
    io.mem_header_o    = '0;
    io.mem_data_o      = '0;
    io.mem_v_o         = 1'b0;
    io.mem_last_o      = 1'b0;
    io.req_ready_and_o = '0;
    grant_id_o         = '0;
    locked_o           = 1'b0;
    if (reset_n_i) begin
      grant_id_o = winner;
      locked_o   = (state_r == e_locked);
      for (int k = 0; k < num_req_p; k++) begin
        if (winner == id_t'(k)) begin
          io.mem_header_o =
            io.req_header_i[k*header_width_p +: header_width_p];
          io.mem_data_o =
            io.req_data_i[k*stream_data_width_p +: stream_data_width_p];
          io.mem_v_o    = io.req_v_i[k];
          io.mem_last_o = io.req_last_i[k];
          io.req_ready_and_o[k] = io.mem_ready_and_i;
        end
      end
    end
  end

  assign hs = io.mem_v_o & io.mem_ready_and_i;

  always_comb begin
    state_n   = state_r;
    lock_id_n = lock_id_r;
    unique case (state_r)
      e_idle: begin
        if (hs && !io.mem_last_o) begin
          state_n   = e_locked;
          lock_id_n = winner;
        end
      end
      e_locked: begin
        if (hs && io.mem_last_o)
          state_n = e_idle;
      end
      default: state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= e_idle;
      lock_id_r <= '0;
    end else begin
      state_r   <= state_n;
      lock_id_r <= lock_id_n;
    end
  end

endmodule

// File: tb/tb_bp_me_stream_arb_out.sv
// Scoreboard bench for bp_me_stream_arb_out: per-requester beat
// queues feed the DUT, a monitor checks every output handshake.
module tb_bp_me_stream_arb_out;
  localparam int N  = 4;
  localparam int HW = 32;
  localparam int DW = 16;
  localparam int LG = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [HW-1:0] hdr;
    logic          last;
  } beat_t;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    logic [HW-1:0] hdr;
    logic          last;
    logic          locked;
  } exp_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [LG-1:0] grant_id;
  logic          locked;

  bp_me_stream_arb_out_if #(
    .num_req_p(N), .header_width_p(HW), .stream_data_width_p(DW)
  ) bus ();

  bp_me_stream_arb_out #(
    .num_req_p(N), .header_width_p(HW), .stream_data_width_p(DW)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (rst_n),
    .io         (bus),
    .grant_id_o (grant_id),
    .locked_o   (locked)
  );

  always #5 clk = ~clk;

  beat_t  srcq[N][$];
  exp_t   sbq[$];
  logic [N-1:0] stall = '0;
  logic [N-1:0] acc   = '0;
  int checks     = 0;
  int failures   = 0;
  int beats_seen = 0;

  function automatic logic [DW-1:0] mk_data(int id, int tag, int b);
    return {id[3:0], tag[7:0], b[3:0]};
  endfunction

  function automatic logic [HW-1:0] mk_hdr(int id, int tag);
    return {id[7:0], tag[7:0], 16'hBEEF};
  endfunction

  task automatic chk(string nm, longint unsigned act, longint unsigned req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // producers: drop accepted head, present next head
  initial begin
    bus.req_header_i    = '0;
    bus.req_data_i      = '0;
    bus.req_v_i         = '0;
    bus.req_last_i      = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && srcq[i].size() > 0)
          void'(srcq[i].pop_front());
        if (srcq[i].size() > 0 && !stall[i]) begin
          bus.req_v_i[i]    = 1'b1;
          bus.req_last_i[i] = srcq[i][0].last;
          bus.req_data_i[i*DW +: DW]   = srcq[i][0].data;
          bus.req_header_i[i*HW +: HW] = srcq[i][0].hdr;
        end else begin
          bus.req_v_i[i]    = 1'b0;
          bus.req_last_i[i] = 1'b0;
          bus.req_data_i[i*DW +: DW]   = '0;
          bus.req_header_i[i*HW +: HW] = '0;
        end
      end
    end
  end

  // monitor
  initial begin
    exp_t e;
    logic [N-1:0] rdy;
    forever begin
      @(negedge clk);
      acc = rst_n ? (bus.req_v_i & bus.req_ready_and_o) : '0;
      if (rst_n && bus.mem_v_o && bus.mem_ready_and_i) begin
        beats_seen++;
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat grant=%0d data=%h required=none",
                   grant_id, bus.mem_data_o);
        end else begin
          e = sbq.pop_front();
          rdy = '0;
          rdy[e.id] = 1'b1;
          chk("grant",  grant_id, e.id);
          chk("data",   bus.mem_data_o, e.data);
          chk("header", bus.mem_header_o, e.hdr);
          chk("last",   bus.mem_last_o, e.last);
          chk("locked", locked, e.locked);
          chk("ready",  bus.req_ready_and_o, rdy);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int id, int n, int tag);
    for (int b = 0; b < n; b++)
      srcq[id].push_back('{data: mk_data(id, tag, b),
                           hdr: mk_hdr(id, tag),
                           last: (b == n-1)});
  endtask

  task automatic expect_part(int id, int n, int tag, int upto);
    for (int b = 0; b < upto; b++)
      sbq.push_back('{id: id, data: mk_data(id, tag, b),
                      hdr: mk_hdr(id, tag), last: (b == n-1),
                      locked: (b > 0)});
  endtask

  task automatic expect_msg(int id, int n, int tag);
    expect_part(id, n, tag, n);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++)
      if (srcq[i].size() > 0) return 1'b0;
    return sbq.size() == 0;
  endfunction

  task automatic wait_drain(string nm, int budget);
    int k = 0;
    while (!all_empty() && k < budget) begin
      cyc();
      k++;
    end
    checks++;
    if (!all_empty()) begin
      failures++;
      $display("FAIL %s_timeout actual=%0d_pending required=0",
               nm, sbq.size());
    end
  endtask

  task automatic wait_beats(string nm, int target, int budget);
    int k = 0;
    while (beats_seen < target && k < budget) begin
      cyc();
      k++;
    end
    checks++;
    if (beats_seen < target) begin
      failures++;
      $display("FAIL %s_timeout actual=%0d required=%0d",
               nm, beats_seen, target);
    end
  endtask

  task automatic chk_zero_out(string nm);
    chk({nm, "_mem_v"},  bus.mem_v_o, 0);
    chk({nm, "_last"},   bus.mem_last_o, 0);
    chk({nm, "_ready"},  bus.req_ready_and_o, 0);
    chk({nm, "_locked"}, locked, 0);
    chk({nm, "_grant"},  grant_id, 0);
  endtask

  initial begin
    int base;
    bus.mem_ready_and_i = 1'b1;

    // contention, loaded while reset is held
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        send(i, 1, 16'h10 + r);
`ifdef BP_ME_STREAM_ARB_OUT_RR_EN
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        expect_msg(i, 1, 16'h10 + r);
`else
    for (int i = 0; i < N; i++)
      for (int r = 0; r < 2; r++)
        expect_msg(i, 1, 16'h10 + r);
`endif
    for (int c = 0; c < 3; c++) begin
      cyc();
      @(negedge clk);
      chk_zero_out("reset");
    end
    cyc();
    rst_n = 1'b1;
    wait_drain("contention", 100);

    // multi-beat lock with a competing requester
    send(1, 4, 8'h20);
    send(2, 1, 8'h21);
    expect_msg(1, 4, 8'h20);
    expect_msg(2, 1, 8'h21);
    wait_drain("lock", 100);

    // bubble and backpressure inside a lock
    base = beats_seen;
    send(0, 4, 8'h30);
    expect_msg(0, 4, 8'h30);
    wait_beats("bubble_first", base + 1, 50);
    stall[0] = 1'b1;
    send(3, 1, 8'h33);
    expect_msg(3, 1, 8'h33);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bubble_rdy3", bus.req_ready_and_o[3], 0);
      chk("bubble_locked", locked, 1);
      chk("bubble_mem_v", bus.mem_v_o, 0);
      cyc();
    end
    stall[0] = 1'b0;
    bus.mem_ready_and_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("bp_rdy", bus.req_ready_and_o, 0);
      chk("bp_mem_v", bus.mem_v_o, 1);
      chk("bp_grant", grant_id, 0);
      cyc();
    end
    bus.mem_ready_and_i = 1'b1;
    wait_drain("bubble", 100);

    // repeated single-beat messages from req1 and req2
    for (int t = 0; t < 3; t++) send(1, 1, 8'h41 + t);
    for (int t = 0; t < 2; t++) send(2, 1, 8'h44 + t);
`ifdef BP_ME_STREAM_ARB_OUT_RR_EN
    expect_msg(1, 1, 8'h41);
    expect_msg(2, 1, 8'h44);
    expect_msg(1, 1, 8'h42);
    expect_msg(2, 1, 8'h45);
    expect_msg(1, 1, 8'h43);
`else
    for (int t = 0; t < 3; t++) expect_msg(1, 1, 8'h41 + t);
    for (int t = 0; t < 2; t++) expect_msg(2, 1, 8'h44 + t);
`endif
    wait_drain("priority", 100);

    // reset in the middle of an 8-beat message
    base = beats_seen;
    send(2, 8, 8'h50);
    expect_part(2, 8, 8'h50, 2);
    wait_beats("midmsg", base + 2, 50);
    rst_n = 1'b0;
    srcq[2].delete();
    send(0, 1, 8'h51);
    send(3, 1, 8'h52);
    expect_msg(0, 1, 8'h51);
    expect_msg(3, 1, 8'h52);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk_zero_out("midreset");
      cyc();
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_locked", locked, 0);
    chk("post_reset_grant", grant_id, 0);
    wait_drain("post_reset", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_me_stream_arb_out.md
BP_ME_STREAM_ARB_OUT -- requirements
Module: bp_me_stream_arb_out

Interface
REQ-001 Parameter num_req_p, default 4: number of requesting BedRock Stream producers, legal range 2..16.
REQ-002 Parameter header_width_p, default 128: BedRock mem header width in bits.
REQ-003 Parameter stream_data_width_p, default 64: beat data width in bits.
REQ-004 Localparam lg_num_req_lp = ceil(log2(num_req_p)).
REQ-005 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset_n_i  in  1  asynchronous, active-low reset.
REQ-007 req_header_i  in  num_req_p*header_width_p  per-requester header; slot i at bits [i*header_width_p +: header_width_p].
REQ-008 req_data_i  in  num_req_p*stream_data_width_p  per-requester beat data.
REQ-009 req_v_i  in  num_req_p  per-requester beat valid.
REQ-010 req_last_i  in  num_req_p  per-requester last-beat flag.
REQ-011 req_ready_and_o  out  num_req_p  per-requester ready-and-valid acceptance.
REQ-012 mem_header_o / mem_data_o / mem_v_o / mem_last_o  out  header_width_p / stream_data_width_p / 1 / 1  arbitrated output stream.
REQ-013 mem_ready_and_i  in  1  downstream ready-and-valid acceptance.
REQ-014 grant_id_o  out  lg_num_req_lp  index of the requester currently driving the output.
REQ-015 locked_o  out  1  high while a multi-beat message is in flight.

Function
REQ-016 Beat handshake on either side: transfer occurs when valid and ready_and are high in the same cycle.
REQ-017 Two-state FSM: IDLE and LOCKED.
REQ-018 In IDLE, the winner is chosen combinationally, in the same cycle, from req_v_i.
REQ-019 With the feature of REQ-031 enabled, the winner is the first set bit of req_v_i at or after rr_ptr_r, scanning upward with modulo-num_req_p wrap.
REQ-020 In LOCKED, the winner is lock_id_r regardless of req_v_i.
REQ-021 Output path is zero-latency pass-through: mem_header_o, mem_data_o and mem_last_o carry the winner's slot.
REQ-022 mem_v_o = req_v_i[winner] in both states; mem_v_o = 0 in IDLE when req_v_i == 0.
REQ-023 req_ready_and_o[winner] = mem_ready_and_i; every other bit of req_ready_and_o is 0.
REQ-024 IDLE->LOCKED on a handshake with mem_last_o = 0; lock_id_r <= winner at the same edge.
REQ-025 LOCKED->IDLE on a handshake with mem_last_o = 1.
REQ-026 IDLE stays IDLE on a handshake with mem_last_o = 1 (single-beat message).
REQ-027 On every handshake with mem_last_o = 1, rr_ptr_r <= (winner + 1) mod num_req_p.
REQ-028 In LOCKED, a bubble (req_v_i[lock_id_r] = 0) holds the lock; no other requester is served.
REQ-029 Once a requester asserts valid, a change in req_v_i of other requesters never alters the winner mid-message.
REQ-030 grant_id_o = winner; locked_o = (state == LOCKED).

Configuration
REQ-031 Macro BP_ME_STREAM_ARB_OUT_RR_EN: when defined, round-robin per REQ-019 and REQ-027; when undefined, fixed priority (lowest index with req_v_i set wins), rr_ptr_r is absent, and all other behaviour is identical.

Reset
REQ-032 While reset_n_i = 0: state = IDLE, lock_id_r = 0, rr_ptr_r = 0, mem_v_o = 0, mem_last_o = 0, req_ready_and_o = 0, locked_o = 0, grant_id_o = 0.
REQ-033 Assertion of reset_n_i mid-message aborts the message; after deassertion the FSM restarts in IDLE with no residual lock.
REQ-034 Reset deassertion is sampled synchronously to clk_i; the first handshake occurs no earlier than the first rising edge after deassertion.

Verification
REQ-035 Single-beat contention: num_req_p=4, RR_EN defined, req_v_i=4'b1111 all last, mem_ready_and_i=1 -> grants 0,1,2,3,0 on consecutive cycles; locked_o never set.
REQ-036 Multi-beat lock: req1 sends a 4-beat message while req2 is valid throughout -> 4 consecutive req1 beats; req2 first granted the cycle after req1's last beat; locked_o high for cycles 2-4.
REQ-037 Bubble and backpressure: req0 in LOCKED drops valid for 3 cycles, and mem_ready_and_i=0 for 2 cycles, while req3 is valid -> req3 never receives ready_and; req0 beat order and data are preserved.
REQ-038 Fixed priority: RR_EN undefined, req_v_i=4'b0110 repeatedly, single-beat messages -> grant always 1 until req1 goes idle, then 2.
REQ-039 Reset mid-message: assert reset_n_i=0 after beat 2 of an 8-beat req2 message -> all outputs 0 during reset; after release, req0 (valid) is granted from IDLE with rr_ptr_r=0.
